// File: rtl/usec_delay_scheduler_pkg.sv
// Shared types and defaults for the microsecond delay scheduler.
// One delay engine is time-shared among several requesters.
package usec_delay_scheduler_pkg;

  localparam int NREQ_DEF = 4;
  localparam int CW_DEF   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/usec_delay_scheduler_if.sv
// Requester-side bundle of the delay scheduler.
// Master = requesters, slave = the scheduler.
interface usec_delay_scheduler_if
  import usec_delay_scheduler_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int CW   = CW_DEF
);

  logic [NREQ-1:0]    req;
  logic [NREQ*CW-1:0] dur;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic               busy;

  modport master (
    output req,
    output dur,
    input  gnt,
    input  done,
    input  busy
  );

  modport slave (
    input  req,
    input  dur,
    output gnt,
    output done,
    output busy
  );

endinterface

// File: rtl/usec_delay_scheduler_rr_arbiter.sv
// Combinational round-robin pick, searching from last+1 upward.
// The last winner gets lowest priority.
module rr_arbiter
  import usec_delay_scheduler_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IW   = idx_w(NREQ_DEF)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] win,
  output logic            valid
);

  always_comb begin
    win   = '0;
    valid = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!valid && req[(int'(last) + k) % NREQ]) begin
        win[(int'(last) + k) % NREQ] = 1'b1;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/usec_delay_scheduler.sv
// Shared microsecond delay engine: round-robin grant,
// tick-driven down-count, one-cycle done pulse.
module usec_delay_scheduler
  import usec_delay_scheduler_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int CW   = CW_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  usec_delay_scheduler_if.slave bus
);

  localparam int IW = idx_w(NREQ);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [IW-1:0]   last_q, last_d;
  logic [IW-1:0]   win_q, win_d;
  logic            busy_q;

  logic [NREQ-1:0] arb_oh;
  logic            arb_valid;
  logic [IW-1:0]   win_c;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req   (bus.req),
    .last  (last_q),
    .win   (arb_oh),
    .valid (arb_valid)
  );

  always_comb begin
    win_c = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_oh[i]) win_c = IW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    last_d  = last_q;
    win_d   = win_q;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d = COUNT;
          cnt_d   = bus.dur[int'(win_c)*CW +: CW];
          gnt_d   = arb_oh;
          win_d   = win_c;
        end
      end
      COUNT: begin
        // A dropped request aborts silently and still rotates priority.
        if (!bus.req[win_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          last_d  = win_q;
        end else if (cnt_q == '0) begin
          state_d = DONE;
          done_d  = gnt_q;
        end else if (tick) begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = DONE;
            done_d  = gnt_q;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
        last_d  = win_q;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      last_q  <= IW'(NREQ - 1);
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= (state_d != IDLE);
      last_q  <= last_d;
      win_q   <= win_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_usec_delay_scheduler.sv
// Bench for usec_delay_scheduler: cycle-level reference
// model plus directed scenarios with literal expectations.
module tb_usec_delay_scheduler;
  import usec_delay_scheduler_pkg::*;

  localparam int NREQ = 4;
  localparam int CW   = 16;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic tick = 1'b0;

  usec_delay_scheduler_if #(.NREQ(NREQ), .CW(CW)) bus();

  usec_delay_scheduler #(.NREQ(NREQ), .CW(CW)) dut (
    .clk  (clk),
    .rst  (rst),
    .tick (tick),
    .bus  (bus)
  );

  always #10 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the engine, how many ticks remain,
  // and whether this is the completion cycle.
  typedef struct {
    int own;
    int rem;
    int last;
    bit fin;
  } model_t;

  localparam model_t M_RST = '{own: -1, rem: 0, last: NREQ-1, fin: 1'b0};

  model_t m = M_RST;

  function automatic model_t step(model_t s, logic [NREQ-1:0] r,
                                  logic [NREQ*CW-1:0] d, logic t);
    model_t n = s;
    if (s.own < 0) begin
      for (int k = 1; k <= NREQ; k++) begin
        int j = (s.last + k) % NREQ;
        if (n.own < 0 && r[j]) begin
          n.own = j;
          n.rem = int'(d[j*CW +: CW]);
          n.fin = 1'b0;
        end
      end
    end else if (s.fin) begin
      n.last = s.own;
      n.own  = -1;
      n.fin  = 1'b0;
    end else if (!r[s.own]) begin
      n.last = s.own;
      n.own  = -1;
    end else if (s.rem == 0) begin
      n.fin = 1'b1;
    end else if (t) begin
      n.rem = s.rem - 1;
      n.fin = (n.rem == 0);
    end
    return n;
  endfunction

  function automatic logic [NREQ-1:0] oh(int i);
    logic [NREQ-1:0] v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  function automatic int idx(logic [NREQ-1:0] v);
    int r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m <= M_RST;
    else      m <= step(m, bus.req, bus.dur, tick);
  end

  always @(negedge clk) begin
    chk("model_gnt",  32'(bus.gnt),  32'(oh(m.own)));
    chk("model_done", 32'(bus.done), m.fin ? 32'(oh(m.own)) : 32'd0);
    chk("model_busy", 32'(bus.busy), 32'(m.own >= 0));
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_tick(int gap);
    repeat (gap) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic set_dur(int i, int v);
    bus.dur[i*CW +: CW] = CW'(v);
  endtask

  int seq[$];
  int exp_seq[5] = '{0, 1, 2, 3, 0};
  int n_done_cyc;
  logic [NREQ-1:0] prev;

  initial begin
    bus.req = '0;
    bus.dur = '0;
    #1 rst = 1'b0;
    #3;
    chk("rst_gnt",  32'(bus.gnt),  0);
    chk("rst_busy", 32'(bus.busy), 0);
    cyc(2);
    rst = 1'b1;
    cyc(1);

    // all requesters, dur=1, tick every cycle: 0,1,2,3,0
    for (int i = 0; i < NREQ; i++) set_dur(i, 1);
    bus.req = 4'b1111;
    tick = 1'b1;
    prev = '0;
    n_done_cyc = 0;
    for (int c = 0; c < 40 && seq.size() < 5; c++) begin
      @(negedge clk);
      if (bus.gnt != 0 && prev == 0) seq.push_back(idx(bus.gnt));
      if (bus.done != 0) n_done_cyc++;
      prev = bus.gnt;
    end
    bus.req = '0;
    tick = 1'b0;
    chk("rr_count", seq.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < seq.size()) chk("rr_order", seq[i], exp_seq[i]);
    chk("rr_done_cycles", n_done_cyc, 4);
    cyc(3);

    // single requester, dur 3, tick every 50 cycles
    set_dur(0, 3);
    bus.req = 4'b0001;
    cyc(1);
    chk("s1_gnt", 32'(bus.gnt), 32'h1);
    pulse_tick(49);
    pulse_tick(49);
    chk("s1_early_done", 32'(bus.done), 0);
    pulse_tick(49);
    chk("s1_done", 32'(bus.done), 32'h1);
    chk("s1_gnt_in_done", 32'(bus.gnt), 32'h1);
    bus.req = '0;
    cyc(1);
    chk("s1_gnt_clear", 32'(bus.gnt), 0);
    chk("s1_busy_clear", 32'(bus.busy), 0);
    cyc(2);

    // zero duration completes without any tick
    set_dur(2, 0);
    bus.req = 4'b0100;
    cyc(1);
    chk("s3_gnt", 32'(bus.gnt), 32'h4);
    cyc(1);
    chk("s3_done", 32'(bus.done), 32'h4);
    bus.req = '0;
    cyc(2);

    // abort of requester 1, pending requester 2 wins next
    set_dur(1, 10);
    bus.req = 4'b0010;
    cyc(1);
    chk("s4_gnt1", 32'(bus.gnt), 32'h2);
    set_dur(2, 2);
    bus.req = 4'b0110;
    repeat (4) pulse_tick(2);
    chk("s4_still1", 32'(bus.gnt), 32'h2);
    bus.req = 4'b0100;
    cyc(1);
    chk("s4_abort_gnt", 32'(bus.gnt), 0);
    chk("s4_abort_done", 32'(bus.done), 0);
    cyc(1);
    chk("s4_gnt2", 32'(bus.gnt), 32'h4);
    pulse_tick(1);
    pulse_tick(1);
    chk("s4_done2", 32'(bus.done), 32'h4);
    bus.req = '0;
    cyc(2);

    // dur changes after grant are ignored
    set_dur(0, 5);
    bus.req = 4'b0001;
    cyc(1);
    chk("s6_gnt", 32'(bus.gnt), 32'h1);
    set_dur(0, 2);
    repeat (4) pulse_tick(1);
    chk("s6_no_early", 32'(bus.done), 0);
    pulse_tick(1);
    chk("s6_done", 32'(bus.done), 32'h1);
    bus.req = '0;
    cyc(2);

    // asynchronous reset mid-count, then re-grant to 0
    set_dur(0, 8);
    bus.req = 4'b0001;
    cyc(1);
    repeat (3) pulse_tick(1);
    chk("s5_busy_pre", 32'(bus.busy), 1);
    #2 rst = 1'b0;
    #1;
    chk("s5_async_gnt",  32'(bus.gnt),  0);
    chk("s5_async_busy", 32'(bus.busy), 0);
    chk("s5_async_done", 32'(bus.done), 0);
    cyc(2);
    rst = 1'b1;
    cyc(1);
    chk("s5_regrant", 32'(bus.gnt), 32'h1);
    bus.req = '0;
    cyc(3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/usec_delay_scheduler.md
USEC_DELAY_SCHEDULER -- requirements
Module: usec_delay_scheduler

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, the number of requesters.
REQ-002 The block SHALL have parameter CW, default 16, the duration width in microseconds.
REQ-003 Port clk, input, 1 bit: single system clock (50 MHz); all state is clocked on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-low; one clock, no other clock domains.
REQ-005 Port tick, input, 1 bit: one-cycle 1 us pulse from the shared microsecond timer.
REQ-006 Port req, input, NREQ bits: per-requester delay request, level, held until done or abort.
REQ-007 Port dur, input, NREQ*CW bits: packed durations; requester i uses bits [i*CW +: CW].
REQ-008 Port gnt, output, NREQ bits: one-hot grant, held for the whole delay owned by that requester.
REQ-009 Port done, output, NREQ bits: one-cycle completion pulse to the owning requester.
REQ-010 Port busy, output, 1 bit: high whenever the delay engine is owned (states COUNT or DONE).

Function
REQ-011 The block SHALL share one CW-bit down-counter among all requesters, with one delay active at a time.
REQ-012 The FSM SHALL have exactly three states: IDLE, COUNT, DONE.
REQ-013 In IDLE with req != 0, the block SHALL pick a winner round-robin, starting at index last+1 mod NREQ.
REQ-014 On that same edge the block SHALL load cnt with dur[winner], set gnt to onehot(winner) and enter COUNT.
REQ-015 Grant latency SHALL be 1 cycle: req sampled high in IDLE at edge k gives gnt high after edge k.
REQ-016 dur SHALL be sampled only at grant; later changes have no effect on the active delay.
REQ-017 In COUNT, each cycle with tick=1 SHALL decrement cnt by 1; cycles with tick=0 SHALL hold cnt.
REQ-018 In COUNT, when tick=1 and cnt==1, the FSM SHALL enter DONE.
REQ-019 A loaded duration of 0 SHALL enter DONE on the next edge, regardless of tick.
REQ-020 Tick counting SHALL start at the first tick after grant, so the elapsed real time is in (N-1, N] us.
REQ-021 In DONE, done[winner] SHALL be high for exactly one cycle; gnt SHALL still be high in that cycle.
REQ-022 On the edge leaving DONE, last SHALL be set to winner, gnt and busy SHALL clear, and the FSM SHALL enter IDLE.
REQ-023 Abort: if req[winner] falls during COUNT, the block SHALL go to IDLE next edge without a done pulse, and last SHALL be set to winner.
REQ-024 Re-arbitration SHALL take at least one IDLE cycle between consecutive grants.
REQ-025 A requester still asserting req after its done SHALL be treated as a new request and SHALL lose priority to other pending requesters.
REQ-026 cnt SHALL never wrap below 0: no decrement in DONE or IDLE.
REQ-027 gnt and done SHALL always be zero or one-hot, and done SHALL be a subset of gnt.

Reset
REQ-028 When rst=0, the block SHALL asynchronously force state=IDLE, cnt=0, gnt=0, done=0, busy=0 and last=NREQ-1, so requester 0 wins first.
REQ-029 Reset asserted mid-delay SHALL discard the delay with no done pulse; operation resumes from IDLE on the first edge after rst rises.

Structure
REQ-030 A shared package SHALL hold the state enum (IDLE, COUNT, DONE) and the defaults for NREQ and CW.
REQ-031 Round-robin selection SHALL be one combinational sub-module, rr_arbiter, with inputs req and last and outputs a one-hot winner and a valid flag.
REQ-032 The top level SHALL contain the FSM, the counter, the last pointer and the output registers; all outputs SHALL be registered.

Verification
REQ-033 Scenario: req=0001, dur0=3, tick every 50 cycles -> gnt=0001 one cycle after req; done[0] pulses once, in the cycle after the 3rd tick; then gnt=0.
REQ-034 Scenario: req=1111 held, all dur=1 -> grants issued in order 0,1,2,3,0; every done pulse is one cycle long; no two grants overlap.
REQ-035 Scenario: req=0100 with dur2=0 -> done[2] high on the second cycle after req, with no tick required.
REQ-036 Scenario: req[1] grant with dur1=10, req[1] dropped after 4 ticks -> returns to IDLE, done stays 0; a pending req[2] is granted next.
REQ-037 Scenario: rst pulled low mid-COUNT with cnt=5 -> outputs clear immediately, without waiting for a clock edge; after release, req=0001 is granted to index 0.
REQ-038 Scenario: dur0 changed from 5 to 2 one cycle after grant -> done[0] still follows the 5th tick.
